// File: rtl/cordic_phase_gen.sv
// cordic_phase_gen
//   Phase front-end for the pipelined CORDIC sin/cos stage. It accumulates a
//   frequency tuning word (FTW) and adds a static phase offset. An optional
//   linear sweep (chirp) steps the FTW once per advance. Full scale 2^32 is 2*pi.
//
// Ports
//   clk_i          system clock, all logic on posedge
//   rst_i          synchronous reset, active-low
//   cfg_load_i     config capture strobe, only honoured in IDLE
//   sweep_mode_i   0 = fixed FTW, 1 = linear sweep
//   ftw_start_i    initial FTW
//   ftw_step_i     signed per-advance FTW increment (sweep only)
//   sweep_len_i    number of FTW increments in the sweep
//   phase_ofs_i    static phase offset
//   en_i           advance enable
//   phase_clr_i    zero the accumulator (phase re-sync)
//   stop_i         abort to IDLE
//   phase_out_o    phase word to CORDIC phase_in
//   phase_vld_o    phase_out_o carries a new sample this cycle
//   sweep_done_o   one-cycle pulse when the sweep completes
//   busy_o         high in RUN or SWEEP
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | waiting for cfg_load, accumulator held
// RUN   | fixed FTW, acc += ftw per enabled cycle
// SWEEP | as RUN, plus ftw += step until len steps done

module cordic_phase_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_load_i,
    input  logic                  sweep_mode_i,
    input  logic [DATA_WIDTH-1:0] ftw_start_i,
    input  logic [DATA_WIDTH-1:0] ftw_step_i,
    input  logic [CNT_WIDTH-1:0]  sweep_len_i,
    input  logic [DATA_WIDTH-1:0] phase_ofs_i,
    input  logic                  en_i,
    input  logic                  phase_clr_i,
    input  logic                  stop_i,
    output logic [DATA_WIDTH-1:0] phase_out_o,
    output logic                  phase_vld_o,
    output logic                  sweep_done_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] ftw_q, ftw_d;
    logic [DATA_WIDTH-1:0] step_q, step_d;
    logic [DATA_WIDTH-1:0] ofs_q, ofs_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] phase_out_q, phase_out_d;
    logic                  phase_vld_q, phase_vld_d;
    logic                  sweep_done_q, sweep_done_d;
    logic                  busy_q, busy_d;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            ftw_q        <= '0;
            step_q       <= '0;
            ofs_q        <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            phase_out_q  <= '0;
            phase_vld_q  <= 1'b0;
            sweep_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            ftw_q        <= ftw_d;
            step_q       <= step_d;
            ofs_q        <= ofs_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            phase_out_q  <= phase_out_d;
            phase_vld_q  <= phase_vld_d;
            sweep_done_q <= sweep_done_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        ftw_d        = ftw_q;
        step_d       = step_q;
        ofs_d        = ofs_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        phase_out_d  = phase_out_q;
        phase_vld_d  = 1'b0;
        sweep_done_d = 1'b0;

        if (stop_i) begin
            state_d = ST_IDLE;
        end else if (phase_clr_i) begin
            acc_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cfg_load_i) begin
                        ftw_d  = ftw_start_i;
                        step_d = ftw_step_i;
                        len_d  = sweep_len_i;
                        ofs_d  = phase_ofs_i;
                        acc_d  = '0;
                        cnt_d  = '0;
                        if (!sweep_mode_i) begin
                            state_d = ST_RUN;
                        end else if (sweep_len_i != '0) begin
                            state_d = ST_SWEEP;
                        end else begin
                            // Zero-length sweep completes immediately.
                            state_d      = ST_RUN;
                            sweep_done_d = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (en_i) begin
                        acc_d       = acc_q + ftw_q;
                        phase_out_d = acc_q + ofs_q;
                        phase_vld_d = 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (en_i) begin
                        acc_d       = acc_q + ftw_q;
                        phase_out_d = acc_q + ofs_q;
                        phase_vld_d = 1'b1;
                        ftw_d       = ftw_q + step_q;
                        cnt_d       = cnt_q + CNT_WIDTH'(1);
                        if (cnt_q == len_q - CNT_WIDTH'(1)) begin
                            state_d      = ST_RUN;
                            sweep_done_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign phase_out_o  = phase_out_q;
    assign phase_vld_o  = phase_vld_q;
    assign sweep_done_o = sweep_done_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_cordic_phase_gen.sv
module tb_cordic_phase_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_load;
    logic        sweep_mode;
    logic [31:0] ftw_start;
    logic [31:0] ftw_step;
    logic [15:0] sweep_len;
    logic [31:0] phase_ofs;
    logic        en;
    logic        phase_clr;
    logic        stop;
    logic [31:0] phase_out;
    logic        phase_vld;
    logic        sweep_done;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    cordic_phase_gen #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_load_i   (cfg_load),
        .sweep_mode_i (sweep_mode),
        .ftw_start_i  (ftw_start),
        .ftw_step_i   (ftw_step),
        .sweep_len_i  (sweep_len),
        .phase_ofs_i  (phase_ofs),
        .en_i         (en),
        .phase_clr_i  (phase_clr),
        .stop_i       (stop),
        .phase_out_o  (phase_out),
        .phase_vld_o  (phase_vld),
        .sweep_done_o (sweep_done),
        .busy_o       (busy)
    );

    // Scoreboard: every valid sample must match the oldest expected phase.
    always @(negedge clk) begin
        if (phase_vld === 1'b1) begin
            logic [31:0] e;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sample_unexpected got=%h exp=none", phase_out);
            end else begin
                e = exp_q.pop_front();
                if (phase_out !== e) $display("FAIL sample got=%h exp=%h", phase_out, e);
                else n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic mode, input logic [31:0] start, input logic [31:0] stp,
                       input logic [15:0] len, input logic [31:0] ofs);
        sweep_mode = mode;
        ftw_start  = start;
        ftw_step   = stp;
        sweep_len  = len;
        phase_ofs  = ofs;
        cfg_load   = 1'b1;
        tick();
        cfg_load   = 1'b0;
    endtask

    task automatic do_stop();
        en   = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        n_checks++; if (phase_out !== 32'h0) $display("FAIL rst_phase got=%h exp=0", phase_out); else n_pass++;
        n_checks++; if (phase_vld !== 1'b0) $display("FAIL rst_vld got=%b exp=0", phase_vld); else n_pass++;
        n_checks++; if (sweep_done !== 1'b0) $display("FAIL rst_done got=%b exp=0", sweep_done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_run_wrap();
        cfg(1'b0, 32'h10000000, 32'h0, 16'd0, 32'h0);
        n_checks++; if (busy !== 1'b1) $display("FAIL run_busy got=%b exp=1", busy); else n_pass++;
        en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            exp_q.push_back(32'(i) * 32'h10000000);
            tick();
        end
        do_stop();
        n_checks++; if (busy !== 1'b0) $display("FAIL stop_busy got=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_quadrants();
        cfg(1'b0, 32'h40000000, 32'h0, 16'd0, 32'h40000000);
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'h40000000 + 32'(i) * 32'h40000000);
            tick();
        end
        do_stop();
    endtask

    task automatic run_sweep(input logic [31:0] start, input logic [31:0] stp,
                             input int len, input logic [31:0] ofs, input int n);
        logic [31:0] acc;
        logic [31:0] f;
        cfg(1'b1, start, stp, 16'(len), ofs);
        acc = 32'h0;
        f   = start;
        en  = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(acc + ofs);
            tick();
            n_checks++;
            if (sweep_done !== (i == len - 1)) $display("FAIL sweep_done i=%0d got=%b exp=%b", i, sweep_done, (i == len - 1));
            else n_pass++;
            n_checks++; if (busy !== 1'b1) $display("FAIL sweep_busy i=%0d got=%b exp=1", i, busy); else n_pass++;
            acc = acc + f;
            if (i < len) f = f + stp;
        end
        do_stop();
    endtask

    task automatic test_sweep();
        run_sweep(32'h01000000, 32'h00100000, 4, 32'h0, 8);
        run_sweep(32'h00000010, 32'hFFFFFFF0, 2, 32'h80000000, 6);
    endtask

    task automatic test_len_zero();
        cfg(1'b1, 32'h02000000, 32'h1, 16'd0, 32'h0);
        n_checks++; if (sweep_done !== 1'b1) $display("FAIL len0_done got=%b exp=1", sweep_done); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL len0_busy got=%b exp=1", busy); else n_pass++;
        en = 1'b1;
        exp_q.push_back(32'h0);
        tick();
        n_checks++; if (sweep_done !== 1'b0) $display("FAIL len0_done_end got=%b exp=0", sweep_done); else n_pass++;
        for (int i = 1; i < 4; i++) begin
            exp_q.push_back(32'(i) * 32'h02000000);
            tick();
        end
        do_stop();
    endtask

    task automatic test_en_toggle();
        cfg(1'b0, 32'h01000000, 32'h0, 16'd0, 32'h5);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'(i) * 32'h01000000 + 32'h5);
            tick();
        end
        en = 1'b0;
        tick();
        n_checks++; if (phase_vld !== 1'b0) $display("FAIL en0_vld got=%b exp=0", phase_vld); else n_pass++;
        n_checks++; if (phase_out !== 32'h02000005) $display("FAIL en0_hold got=%h exp=02000005", phase_out); else n_pass++;
        en = 1'b1;
        for (int i = 3; i < 6; i++) begin
            exp_q.push_back(32'(i) * 32'h01000000 + 32'h5);
            tick();
        end
        do_stop();
    endtask

    task automatic test_clr_cfg_ignore();
        cfg(1'b0, 32'h00300000, 32'h0, 16'd0, 32'h1234);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'(i) * 32'h00300000 + 32'h1234);
            tick();
        end
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        n_checks++; if (phase_vld !== 1'b0) $display("FAIL clr_vld got=%b exp=0", phase_vld); else n_pass++;
        sweep_mode = 1'b1;
        ftw_start  = 32'hDEADBEEF;
        ftw_step   = 32'h11111111;
        sweep_len  = 16'd3;
        phase_ofs  = 32'h77;
        cfg_load   = 1'b1;
        exp_q.push_back(32'h1234);
        tick();
        cfg_load = 1'b0;
        exp_q.push_back(32'h00301234);
        tick();
        exp_q.push_back(32'h00601234);
        tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL cfg_ignored_busy got=%b exp=1", busy); else n_pass++;
        do_stop();
    endtask

    task automatic test_abort_mid_sweep(input logic use_rst);
        cfg(1'b1, 32'h01000000, 32'h00100000, 16'd4, 32'h0);
        en = 1'b1;
        exp_q.push_back(32'h0);
        tick();
        exp_q.push_back(32'h01000000);
        tick();
        if (use_rst) rst = 1'b0; else stop = 1'b1;
        tick();
        rst  = 1'b1;
        stop = 1'b0;
        en   = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy rst=%b got=%b exp=0", use_rst, busy); else n_pass++;
        n_checks++; if (phase_vld !== 1'b0) $display("FAIL abort_vld rst=%b got=%b exp=0", use_rst, phase_vld); else n_pass++;
        n_checks++; if (sweep_done !== 1'b0) $display("FAIL abort_done rst=%b got=%b exp=0", use_rst, sweep_done); else n_pass++;
        if (use_rst) begin
            n_checks++; if (phase_out !== 32'h0) $display("FAIL abort_rst_phase got=%h exp=0", phase_out); else n_pass++;
        end else begin
            n_checks++; if (phase_out !== 32'h01000000) $display("FAIL abort_stop_hold got=%h exp=01000000", phase_out); else n_pass++;
        end
        tick();
        tick();
        n_checks++; if (sweep_done !== 1'b0) $display("FAIL abort_done_late rst=%b got=%b exp=0", use_rst, sweep_done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_idle rst=%b got=%b exp=0", use_rst, busy); else n_pass++;
    endtask

    initial begin
        rst        = 1'b0;
        cfg_load   = 1'b0;
        sweep_mode = 1'b0;
        ftw_start  = 32'h0;
        ftw_step   = 32'h0;
        sweep_len  = 16'h0;
        phase_ofs  = 32'h0;
        en         = 1'b1;
        phase_clr  = 1'b0;
        stop       = 1'b0;
        tick();
        tick();
        test_reset();
        rst = 1'b1;
        en  = 1'b0;
        tick();

        test_run_wrap();
        test_quadrants();
        test_sweep();
        test_len_zero();
        test_en_toggle();
        test_clr_cfg_ignore();
        test_abort_mid_sweep(1'b0);
        test_abort_mid_sweep(1'b1);

        tick();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL samples_missing got=%0d exp=0", exp_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
